// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer.
// Holds the per-key FSM state encoding and the default timing constants
// (50 MHz clock, 20 ms debounce window, 1 s long-press threshold).
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } key_fsm_e;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;

  localparam int DEF_DEBOUNCE_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEF_LONG_CYC     = (CLK_HZ / 1000) * LONG_MS;

endpackage

// File: rtl/key_debounce_one.sv
// Single-key debouncer: 2-flop synchronizer, debounce FSM, long-press timer.
// Latency: press/release pulse DEBOUNCE_CYC+2 edges after key_in is first sampled.
// Backpressure: none; event outputs are single-cycle pulses, never held.
// Ports: clk, rst_n (async, active-low), key_in (raw, active-low),
//        key_state (1 = held), key_press / key_release / key_long (pulses).
module key_debounce_one
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,  // >= 2
  parameter int LONG_CYC     = DEF_LONG_CYC       // > DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int LW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] L_PRE  = LW'(LONG_CYC - 2);

  // Synchronizer resets to 1 so a held key after reset looks like a fresh press.
  logic sync1, s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= key_in;
      s     <= sync1;
    end
  end

  key_fsm_e      state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic          press_n, release_n, long_n;

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    lcnt_n    = lcnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!s) begin
          state_n = PRESS_WAIT;
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        // A bounce back to high wins even on the final count.
        if (s) begin
          state_n = IDLE;
        end else if (dcnt == D_LAST) begin
          state_n = PRESSED;
          press_n = 1'b1;
          lcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        // Saturating hold timer; the pulse marks the single step onto L_LAST.
        if (lcnt != L_LAST) begin
          lcnt_n = lcnt + 1'b1;
          long_n = (lcnt == L_PRE);
        end
        if (s) begin
          state_n = REL_WAIT;
          dcnt_n  = '0;
        end
      end
      REL_WAIT: begin
        // lcnt is frozen here, so key_long can never coincide with key_release.
        if (!s) begin
          state_n = PRESSED;
        end else if (dcnt == D_LAST) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dcnt        <= '0;
      lcnt        <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      lcnt        <= lcnt_n;
      key_state   <= (state_n == PRESSED) || (state_n == REL_WAIT);
      key_press   <= press_n;
      key_release <= release_n;
      key_long    <= long_n;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: KEY_W independent key_debounce_one lanes plus any_press.
// Latency: DEBOUNCE_CYC+2 edges from first sample of a key change to its pulse.
// Backpressure: none; pulses are one cycle wide and must be consumed when seen.
// Ports: clk, rst_n (async, active-low), key_in[KEY_W] (active-low pins),
//        key_state / key_press / key_release / key_long [KEY_W], any_press.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_W        = 4,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic             any_press
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_key (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

  // OR of registered pulses, so it lines up with key_press in the same cycle.
  assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int KW   = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] key_in = '1;
  logic [KW-1:0] key_state, key_press, key_release, key_long;
  logic          any_press;

  key_debounce #(.KEY_W(KW), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: the debounced level flips once the synchronized input
  // has disagreed with it for DEB+1 consecutive samples; the hold timer
  // advances on every pressed-level sample whose previous sample was low.
  bit            d1[KW], d2[KW], lvl[KW], prev_s[KW];
  int            run[KW], hold[KW];
  bit            s_v;
  logic [KW-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KW; i++) begin
        d1[i] = 1; d2[i] = 1; lvl[i] = 0; prev_s[i] = 1; run[i] = 0; hold[i] = 0;
      end
      m_state = '0; m_press = '0; m_rel = '0; m_long = '0;
    end else begin
      for (int i = 0; i < KW; i++) begin
        s_v   = d2[i];
        d2[i] = d1[i];
        d1[i] = key_in[i];
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
        if (!lvl[i]) begin
          run[i] = s_v ? 0 : run[i] + 1;
          if (run[i] == DEB + 1) begin
            lvl[i] = 1; m_press[i] = 1'b1; run[i] = 0; hold[i] = 0;
          end
        end else begin
          if (!prev_s[i] && hold[i] < LONG - 1) begin
            hold[i]++;
            if (hold[i] == LONG - 1) m_long[i] = 1'b1;
          end
          run[i] = s_v ? run[i] + 1 : 0;
          if (run[i] == DEB + 1) begin
            lvl[i] = 0; m_rel[i] = 1'b1; run[i] = 0;
          end
        end
        prev_s[i] = s_v;
        m_state[i] = lvl[i];
      end
    end
  end

  // Per-cycle compare plus event log used by the literal checks.
  int n_press[KW], t_press[KW], n_rel[KW], t_rel[KW], n_long[KW], t_long[KW];
  int n_any = 0, t_any = -1;

  initial begin
    for (int i = 0; i < KW; i++) begin
      n_press[i] = 0; t_press[i] = -1; n_rel[i] = 0; t_rel[i] = -1;
      n_long[i] = 0; t_long[i] = -1;
    end
  end

  always @(negedge clk) begin
    chk("key_state", int'(key_state), int'(m_state));
    chk("key_press", int'(key_press), int'(m_press));
    chk("key_release", int'(key_release), int'(m_rel));
    chk("key_long", int'(key_long), int'(m_long));
    chk("any_press", int'(any_press), int'(|m_press));
    for (int i = 0; i < KW; i++) begin
      if (key_press[i])   begin n_press[i]++; t_press[i] = cyc; end
      if (key_release[i]) begin n_rel[i]++;   t_rel[i]   = cyc; end
      if (key_long[i])    begin n_long[i]++;  t_long[i]  = cyc; end
    end
    if (any_press) begin n_any++; t_any = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k, j, base_any, base_rel0, base_rel2;

  initial begin
    // Reset state
    tick(3);
    chk("reset_state", int'(key_state), 0);
    chk("reset_pulses", int'({key_press, key_release, key_long, any_press}), 0);
    #2 rst_n = 1'b1;
    tick(3);

    // Clean press on key 0
    key_in[0] = 1'b0; k = cyc + 1;
    tick(15);
    chk("clean_press_cnt", n_press[0], 1);
    chk("clean_press_time", t_press[0], k + 10);
    chk("clean_any_time", t_any, k + 10);
    chk("clean_state", int'(key_state), 4'b0001);
    chk("clean_other_press", n_press[1] + n_press[2] + n_press[3], 0);
    key_in[0] = 1'b1; j = cyc + 1;
    tick(14);
    chk("clean_release_time", t_rel[0], j + 10);
    chk("clean_no_long", n_long[0], 0);

    // Bounce rejection on key 1
    for (int r = 0; r < 3; r++) begin
      key_in[1] = 1'b0; tick(5);
      key_in[1] = 1'b1; tick(5);
    end
    chk("bounce_no_press", n_press[1], 0);
    chk("bounce_state", int'(key_state[1]), 0);
    key_in[1] = 1'b0; k = cyc + 1;
    tick(15);
    chk("bounce_then_press", n_press[1], 1);
    chk("bounce_press_time", t_press[1], k + 10);
    key_in[1] = 1'b1;
    tick(14);

    // Long press on key 2
    key_in[2] = 1'b0; k = cyc + 1;
    tick(60);
    chk("long_press_time", t_press[2], k + 10);
    chk("long_time", t_long[2], k + 41);
    chk("long_once", n_long[2], 1);
    key_in[2] = 1'b1; j = cyc + 1;
    tick(14);
    chk("long_release_time", t_rel[2], j + 10);
    chk("long_release_once", n_rel[2], 1);
    chk("long_no_repeat", n_long[2], 1);

    // Release bounce on key 3: 4 high samples stretch the hold timer by 4
    key_in[3] = 1'b0; k = cyc + 1;
    tick(20);
    key_in[3] = 1'b1; tick(4);
    key_in[3] = 1'b0;
    tick(40);
    chk("relbounce_no_release", n_rel[3], 0);
    chk("relbounce_state", int'(key_state[3]), 1);
    chk("relbounce_long_time", t_long[3], k + 45);
    key_in[3] = 1'b1;
    tick(14);
    chk("relbounce_final_release", n_rel[3], 1);

    // Simultaneous press on all keys
    base_any = n_any;
    key_in = 4'b0000; k = cyc + 1;
    tick(14);
    chk("simul_press_vec", int'({t_press[3] == k + 10, t_press[2] == k + 10,
                                 t_press[1] == k + 10, t_press[0] == k + 10}), 4'b1111);
    chk("simul_any_once", n_any - base_any, 1);
    chk("simul_state", int'(key_state), 4'b1111);
    key_in = 4'b1111;
    tick(14);

    // Reset mid-operation: key 2 pressed, key 0 in its debounce window
    key_in[2] = 1'b0;
    tick(14);
    key_in[0] = 1'b0;
    tick(8);
    chk("pre_reset_state", int'(key_state), 4'b0100);
    base_rel0 = n_rel[0]; base_rel2 = n_rel[2];
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_state", int'(key_state), 0);
    chk("mid_reset_pulses", int'({key_press, key_release, key_long, any_press}), 0);
    tick(3);
    #2 rst_n = 1'b1;
    k = cyc + 1;
    tick(14);
    chk("post_reset_press0", t_press[0], k + 10);
    chk("post_reset_press2", t_press[2], k + 10);
    chk("post_reset_no_release", (n_rel[0] - base_rel0) + (n_rel[2] - base_rel2), 0);
    key_in = 4'b1111;
    tick(14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
